// File: rtl/sync_fifo_pkg.sv
// Shared constants and types for the single-clock FIFO.
// The write side, the read side and the storage array all use these sizes.
package async_fifo_pkg;

   // Width of one stored word.
   localparam int FIFO_DATA_WIDTH     = 8;
   // Number of memory address bits.
   localparam int FIFO_MEM_ADDR_WIDTH = 4;
   // Number of words the FIFO can hold.
   localparam int FIFO_DEPTH          = 2 ** FIFO_MEM_ADDR_WIDTH;
   // Each pointer has one extra wrap bit, which separates full from empty.
   localparam int FIFO_PTR_WIDTH      = FIFO_MEM_ADDR_WIDTH + 1;

   typedef logic [FIFO_DATA_WIDTH-1:0]     fifo_data_t;
   typedef logic [FIFO_MEM_ADDR_WIDTH-1:0] fifo_addr_t;
   typedef logic [FIFO_PTR_WIDTH-1:0]      fifo_ptr_t;

endpackage : async_fifo_pkg

// File: rtl/sync_fifo_if.sv
// Producer/consumer handshake bundle for sync_fifo.
// The master modport is the traffic source and sink. The slave modport is the FIFO.
interface sync_fifo_if
   import async_fifo_pkg::*;
#(
   parameter int DSIZE = FIFO_DATA_WIDTH
);
   // Write side
   logic             winc;
   logic [DSIZE-1:0] wdata;
   logic             wfull;
   // Read side
   logic             rinc;
   logic [DSIZE-1:0] rdata;
   logic             rempty;

   modport master (
      output winc,
      output wdata,
      input  wfull,
      output rinc,
      input  rdata,
      input  rempty
   );

   modport slave (
      input  winc,
      input  wdata,
      output wfull,
      input  rinc,
      output rdata,
      output rempty
   );

endinterface : sync_fifo_if

// File: rtl/sync_fifo_mem.sv
// Storage array for sync_fifo.
// The write port is synchronous. The read port is asynchronous, so the head word
// appears on the output without waiting for a clock edge.
module fifo_mem
   import async_fifo_pkg::*;
#(
   parameter int DSIZE = FIFO_DATA_WIDTH,
   parameter int ASIZE = FIFO_MEM_ADDR_WIDTH
) (
   input  logic             clk,
   input  logic             wclken_i,
   input  logic [ASIZE-1:0] waddr_i,
   input  logic [DSIZE-1:0] wdata_i,
   input  logic [ASIZE-1:0] raddr_i,
   output logic [DSIZE-1:0] rdata_o
);
   localparam int DEPTH = 1 << ASIZE;

   // The array has no reset. Stale words are only visible while the FIFO is empty,
   // and rdata is meaningless in that state.
   logic [DSIZE-1:0] mem_q [DEPTH];

   // Write the addressed word when the top level accepts a write.
   always_ff @(posedge clk) begin
      if (wclken_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   // The head word falls through combinationally.
   assign rdata_o = mem_q[raddr_i];

endmodule : fifo_mem

// File: rtl/sync_fifo.sv
// Single-clock, first-word-fall-through FIFO.
// This level holds the read/write pointers, the accept logic and the registered
// full/empty flags. Storage lives in fifo_mem.
module sync_fifo
   import async_fifo_pkg::*;
#(
   parameter int DSIZE = FIFO_DATA_WIDTH,
   parameter int ASIZE = FIFO_MEM_ADDR_WIDTH
) (
   input  logic        clk,
   input  logic        rst,
   sync_fifo_if.slave  bus
);
   localparam int                 PTR_W   = ASIZE + 1;
   localparam logic [PTR_W-1:0]   PTR_ONE = PTR_W'(1);

   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic             rempty_q, rempty_d;
   logic             wfull_q, wfull_d;
   logic             wen, ren;
   logic [DSIZE-1:0] mem_rdata;

   // Qualify the requests with the registered flags.
   // Each pointer then moves to its next value. The flags are derived from the
   // next-state pointers, so they settle one cycle after the operation.
   always_comb begin
      wen      = bus.winc & ~wfull_q;
      ren      = bus.rinc & ~rempty_q;
      wptr_d   = wen ? (wptr_q + PTR_ONE) : wptr_q;
      rptr_d   = ren ? (rptr_q + PTR_ONE) : rptr_q;
      rempty_d = (wptr_d == rptr_d);
      wfull_d  = (wptr_d[ASIZE] != rptr_d[ASIZE]) &&
                 (wptr_d[ASIZE-1:0] == rptr_d[ASIZE-1:0]);
   end

   // Pointer and flag registers. Reset wins over any request in the same cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         rempty_q <= 1'b1;
         wfull_q  <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         rempty_q <= rempty_d;
         wfull_q  <= wfull_d;
      end
   end

   // Suppress the array write during reset, so that reset really overrides winc.
   fifo_mem #(
      .DSIZE (DSIZE),
      .ASIZE (ASIZE)
   ) u_mem (
      .clk      (clk),
      .wclken_i (wen & ~rst),
      .waddr_i  (wptr_q[ASIZE-1:0]),
      .wdata_i  (bus.wdata),
      .raddr_i  (rptr_q[ASIZE-1:0]),
      .rdata_o  (mem_rdata)
   );

   assign bus.rdata  = mem_rdata;
   assign bus.rempty = rempty_q;
   assign bus.wfull  = wfull_q;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Self-checking bench for sync_fifo.
// A queue tracks the words that should be inside the FIFO. A word is pushed when
// the model accepts a write, and is compared and popped when the model accepts a read.
module tb_sync_fifo;
   import async_fifo_pkg::*;

   logic clk = 1'b0;
   logic rst = 1'b1;

   sync_fifo_if bus ();

   sync_fifo dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   logic [7:0] sb[$];
   int         n_total = 0;
   int         n_pass  = 0;
   logic [7:0] exp_d;

   // Drive one clock cycle of stimulus and update the reference queue.
   // Acceptance is computed from the model's own occupancy before the edge.
   task automatic cycle(input bit r_st, input bit w, input logic [7:0] d, input bit r);
      bit m_wen, m_ren;
      rst       = r_st;
      bus.winc  = w;
      bus.wdata = d;
      bus.rinc  = r;
      m_wen = w && (sb.size() < FIFO_DEPTH);
      m_ren = r && (sb.size() > 0);
      @(posedge clk);
      if (r_st) sb.delete();
      else begin
         if (m_ren) void'(sb.pop_front());
         if (m_wen) sb.push_back(d);
      end
      @(negedge clk);
      rst      = 1'b0;
      bus.winc = 1'b0;
      bus.rinc = 1'b0;
   endtask

   task automatic test_reset();
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      cycle(1'b1, 1'b0, 8'h00, 1'b1);
      n_total++;
      if (bus.rempty !== 1'b1) $display("FAIL reset_rempty got=%b exp=1", bus.rempty); else n_pass++;
      n_total++;
      if (bus.wfull !== 1'b0) $display("FAIL reset_wfull got=%b exp=0", bus.wfull); else n_pass++;
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      n_total++;
      if (bus.rempty !== 1'b1) $display("FAIL reset_rinc_empty got=%b exp=1", bus.rempty); else n_pass++;
      cycle(1'b0, 1'b1, 8'h33, 1'b0);
      exp_d = sb[0];
      n_total++;
      if (bus.rdata !== exp_d) $display("FAIL reset_first_word got=%h exp=%h", bus.rdata, exp_d); else n_pass++;
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      $display("test_reset done");
   endtask

   task automatic test_fill();
      for (int i = 0; i < 16; i++) begin
         n_total++;
         if (bus.wfull !== 1'b0) $display("FAIL fill_wfull_early i=%0d got=%b exp=0", i, bus.wfull); else n_pass++;
         cycle(1'b0, 1'b1, 8'(i), 1'b0);
         n_total++;
         if (bus.rempty !== 1'b0) $display("FAIL fill_rempty i=%0d got=%b exp=0", i, bus.rempty); else n_pass++;
      end
      n_total++;
      if (bus.wfull !== 1'b1) $display("FAIL fill_wfull got=%b exp=1", bus.wfull); else n_pass++;
      cycle(1'b0, 1'b1, 8'hAA, 1'b0);
      n_total++;
      if (bus.wfull !== 1'b1) $display("FAIL fill_drop_wfull got=%b exp=1", bus.wfull); else n_pass++;
      $display("test_fill done, model occupancy=%0d", sb.size());
   endtask

   task automatic test_drain();
      for (int i = 0; i < 16; i++) begin
         exp_d = sb[0];
         n_total++;
         if (bus.rdata !== exp_d) $display("FAIL drain_data i=%0d got=%h exp=%h", i, bus.rdata, exp_d); else n_pass++;
         n_total++;
         if (bus.rempty !== 1'b0) $display("FAIL drain_rempty i=%0d got=%b exp=0", i, bus.rempty); else n_pass++;
         cycle(1'b0, 1'b0, 8'h00, 1'b1);
         n_total++;
         if (bus.wfull !== 1'b0) $display("FAIL drain_wfull i=%0d got=%b exp=0", i, bus.wfull); else n_pass++;
      end
      n_total++;
      if (bus.rempty !== 1'b1) $display("FAIL drain_empty got=%b exp=1", bus.rempty); else n_pass++;
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      n_total++;
      if (bus.rempty !== 1'b1) $display("FAIL drain_extra_empty got=%b exp=1", bus.rempty); else n_pass++;
      cycle(1'b0, 1'b1, 8'h77, 1'b0);
      exp_d = sb[0];
      n_total++;
      if (bus.rdata !== exp_d) $display("FAIL drain_extra_rptr got=%h exp=%h", bus.rdata, exp_d); else n_pass++;
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      $display("test_drain done");
   endtask

   task automatic test_wrap();
      for (int rep = 0; rep < 5; rep++) begin
         for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b1, 8'(rep * 16 + i + 1), 1'b0);
            n_total++;
            if (bus.wfull !== 1'b0) $display("FAIL wrap_wfull rep=%0d got=%b exp=0", rep, bus.wfull); else n_pass++;
         end
         for (int i = 0; i < 10; i++) begin
            exp_d = sb[0];
            n_total++;
            if (bus.rdata !== exp_d || bus.rempty !== 1'b0)
               $display("FAIL wrap_read rep=%0d i=%0d got=%h/%b exp=%h/0", rep, i, bus.rdata, bus.rempty, exp_d);
            else n_pass++;
            cycle(1'b0, 1'b0, 8'h00, 1'b1);
         end
         n_total++;
         if (bus.rempty !== 1'b1) $display("FAIL wrap_empty rep=%0d got=%b exp=1", rep, bus.rempty); else n_pass++;
      end
      $display("test_wrap done");
   endtask

   task automatic test_simultaneous();
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
      for (int k = 0; k < 20; k++) begin
         exp_d = sb[0];
         n_total++;
         if (bus.rdata !== exp_d || bus.rempty !== 1'b0 || bus.wfull !== 1'b0)
            $display("FAIL simul k=%0d got=%h/%b/%b exp=%h/0/0", k, bus.rdata, bus.rempty, bus.wfull, exp_d);
         else n_pass++;
         cycle(1'b0, 1'b1, 8'(8'hC0 + k), 1'b1);
      end
      for (int i = 0; i < 8; i++) begin
         exp_d = sb[0];
         n_total++;
         if (bus.rdata !== exp_d) $display("FAIL simul_drain i=%0d got=%h exp=%h", i, bus.rdata, exp_d); else n_pass++;
         cycle(1'b0, 1'b0, 8'h00, 1'b1);
      end
      n_total++;
      if (bus.rempty !== 1'b1) $display("FAIL simul_empty got=%b exp=1", bus.rempty); else n_pass++;
      $display("test_simultaneous done");
   endtask

   task automatic test_corner_both();
      // Empty FIFO with winc & rinc: only the write happens.
      cycle(1'b0, 1'b1, 8'h11, 1'b1);
      exp_d = sb[0];
      n_total++;
      if (bus.rempty !== 1'b0 || bus.rdata !== exp_d)
         $display("FAIL empty_both got=%b/%h exp=0/%h", bus.rempty, bus.rdata, exp_d);
      else n_pass++;
      for (int i = 0; i < 15; i++) cycle(1'b0, 1'b1, 8'(8'h20 + i), 1'b0);
      n_total++;
      if (bus.wfull !== 1'b1) $display("FAIL corner_full got=%b exp=1", bus.wfull); else n_pass++;
      // Full FIFO with winc & rinc: only the read happens.
      cycle(1'b0, 1'b1, 8'hEE, 1'b1);
      n_total++;
      if (bus.wfull !== 1'b0) $display("FAIL full_both got=%b exp=0", bus.wfull); else n_pass++;
      for (int i = 0; i < 15; i++) begin
         exp_d = sb[0];
         n_total++;
         if (bus.rdata !== exp_d) $display("FAIL corner_drain i=%0d got=%h exp=%h", i, bus.rdata, exp_d); else n_pass++;
         cycle(1'b0, 1'b0, 8'h00, 1'b1);
      end
      n_total++;
      if (bus.rempty !== 1'b1) $display("FAIL corner_empty got=%b exp=1", bus.rempty); else n_pass++;
      $display("test_corner_both done");
   endtask

   task automatic test_mid_reset();
      for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'(8'h40 + i), 1'b0);
      cycle(1'b1, 1'b1, 8'h99, 1'b0);
      n_total++;
      if (bus.rempty !== 1'b1 || bus.wfull !== 1'b0)
         $display("FAIL midrst_flags got=%b/%b exp=1/0", bus.rempty, bus.wfull);
      else n_pass++;
      cycle(1'b0, 1'b1, 8'h5A, 1'b0);
      exp_d = sb[0];
      n_total++;
      if (bus.rdata !== exp_d || bus.rempty !== 1'b0)
         $display("FAIL midrst_data got=%h/%b exp=%h/0", bus.rdata, bus.rempty, exp_d);
      else n_pass++;
      cycle(1'b0, 1'b0, 8'h00, 1'b1);
      n_total++;
      if (bus.rempty !== 1'b1) $display("FAIL midrst_empty got=%b exp=1", bus.rempty); else n_pass++;
      $display("test_mid_reset done");
   endtask

   initial begin
      bus.winc  = 1'b0;
      bus.rinc  = 1'b0;
      bus.wdata = '0;
      @(negedge clk);
      test_reset();
      test_fill();
      test_drain();
      test_wrap();
      test_simultaneous();
      test_corner_both();
      test_mid_reset();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule : tb_sync_fifo
